// File: rtl/i2c_byte_ctrl_pkg.sv
// Shared I2C definitions: bit-engine command codes and byte sequencer states.
// Also used by the sibling bit-level engine i2c_bit_ctrl.
package pck_i2c;

    typedef enum logic [2:0] {
        BIT_NOP   = 3'd0,
        BIT_START = 3'd1,
        BIT_STOP  = 3'd2,
        BIT_WRITE = 3'd3,
        BIT_READ  = 3'd4
    } i2c_bit_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_ACK   = 3'd4,
        ST_STOP  = 3'd5
    } i2c_byte_state_e;

endpackage

// File: rtl/i2c_byte_ctrl.sv
// I2C byte sequencer: expands one register command into bit-engine commands,
// shifts data MSB first and maintains the tip/ip/al/rxack status and irq.
module i2c_byte_ctrl
    import pck_i2c::*;
(
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_enable,
    input  logic       i_ien,
    input  logic       i_cmd_valid,
    input  logic       i_cmd_start,
    input  logic       i_cmd_stop,
    input  logic       i_cmd_read,
    input  logic       i_cmd_write,
    input  logic       i_cmd_ack,
    input  logic       i_cmd_iack,
    input  logic [7:0] i_tx_data,
    output logic [7:0] o_rx_data,
    output logic       o_tip,
    output logic       o_ip,
    output logic       o_al,
    output logic       o_rxack,
    output logic       o_irq,
    output logic [2:0] o_bit_cmd,
    output logic       o_bit_cmd_valid,
    output logic       o_bit_din,
    input  logic       i_bit_ack,
    input  logic       i_bit_dout,
    input  logic       i_bit_al
);

    i2c_byte_state_e state, next_state;
    i2c_bit_cmd_e    bit_cmd;
    logic [7:0]      shreg;
    logic [2:0]      cnt;
    logic            read_flag, write_flag, stop_flag, ack_flag;
    logic            accept, take, done, abort_al, abort_en;

    assign o_bit_cmd = bit_cmd;
    assign o_irq     = o_ip & i_ien;

    // Bit command and SDA level follow purely from registered state, so they
    // stay stable for as long as the command is presented.
    always_comb begin
        bit_cmd    = BIT_NOP;
        o_bit_din  = 1'b0;
        next_state = state;
        accept     = 1'b0;
        take       = 1'b0;
        done       = 1'b0;
        abort_al   = 1'b0;
        abort_en   = 1'b0;

        case (state)
            ST_START: bit_cmd = BIT_START;
            ST_WRITE: begin
                bit_cmd   = BIT_WRITE;
                o_bit_din = shreg[7];
            end
            ST_READ:  bit_cmd = BIT_READ;
            ST_ACK: begin
                bit_cmd   = read_flag ? BIT_WRITE : BIT_READ;
                o_bit_din = read_flag & ack_flag;
            end
            ST_STOP:  bit_cmd = BIT_STOP;
            default:  bit_cmd = BIT_NOP;
        endcase

        if (state == ST_IDLE) begin
            accept = i_cmd_valid & i_enable &
                     (i_cmd_start | i_cmd_stop | i_cmd_read | i_cmd_write);
            if (accept) begin
                next_state = i_cmd_start ? ST_START :
                             i_cmd_read  ? ST_READ  :
                             i_cmd_write ? ST_WRITE : ST_STOP;
            end
        end else if (i_bit_al) begin
            abort_al   = 1'b1;
            next_state = ST_IDLE;
        end else if (!i_enable) begin
            abort_en   = 1'b1;
            next_state = ST_IDLE;
        end else if (i_bit_ack && o_bit_cmd_valid) begin
            take = 1'b1;
            case (state)
                ST_START: next_state = read_flag  ? ST_READ  :
                                       write_flag ? ST_WRITE : ST_STOP;
                ST_WRITE, ST_READ: begin
                    if (cnt == 3'd0) next_state = ST_ACK;
                end
                ST_ACK: begin
                    if (stop_flag) begin
                        next_state = ST_STOP;
                    end else begin
                        next_state = ST_IDLE;
                        done       = 1'b1;
                    end
                end
                ST_STOP: begin
                    next_state = ST_IDLE;
                    done       = 1'b1;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Later assignments deliberately override earlier ones: a same-cycle done
    // or arbitration loss beats iack, and arbitration loss beats accept on al.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state           <= ST_IDLE;
            shreg           <= 8'h00;
            cnt             <= 3'd0;
            read_flag       <= 1'b0;
            write_flag      <= 1'b0;
            stop_flag       <= 1'b0;
            ack_flag        <= 1'b0;
            o_rx_data       <= 8'h00;
            o_tip           <= 1'b0;
            o_ip            <= 1'b0;
            o_al            <= 1'b0;
            o_rxack         <= 1'b0;
            o_bit_cmd_valid <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                read_flag       <= i_cmd_read;
                write_flag      <= i_cmd_write;
                stop_flag       <= i_cmd_stop;
                ack_flag        <= i_cmd_ack;
                shreg           <= i_tx_data;
                cnt             <= 3'd7;
                o_al            <= 1'b0;
                o_tip           <= 1'b1;
                o_bit_cmd_valid <= 1'b1;
            end
            if (take) begin
                case (state)
                    ST_WRITE: begin
                        shreg <= {shreg[6:0], 1'b0};
                        cnt   <= cnt - 3'd1;
                    end
                    ST_READ: begin
                        shreg <= {shreg[6:0], i_bit_dout};
                        cnt   <= cnt - 3'd1;
                        if (cnt == 3'd0) o_rx_data <= {shreg[6:0], i_bit_dout};
                    end
                    ST_ACK: begin
                        if (!read_flag) o_rxack <= i_bit_dout;
                    end
                    default: ;
                endcase
            end
            if (done || abort_al || abort_en) begin
                o_tip           <= 1'b0;
                o_bit_cmd_valid <= 1'b0;
            end
            if (done) begin
                read_flag  <= 1'b0;
                write_flag <= 1'b0;
                stop_flag  <= 1'b0;
                ack_flag   <= 1'b0;
            end
            if (i_cmd_valid && i_cmd_iack) o_ip <= 1'b0;
            if (done || abort_al) o_ip <= 1'b1;
            if (i_bit_al) o_al <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Directed bench for i2c_byte_ctrl; models the bit engine acking each
// command four cycles after it is presented.
module tb_i2c_byte_ctrl;
    import pck_i2c::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       enable = 1'b0;
    logic       ien = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_start = 1'b0;
    logic       cmd_stop = 1'b0;
    logic       cmd_read = 1'b0;
    logic       cmd_write = 1'b0;
    logic       cmd_ack = 1'b0;
    logic       cmd_iack = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       tip, ip, al, rxack, irq;
    logic [2:0] bit_cmd;
    logic       bit_cmd_valid, bit_din;
    logic       bit_ack = 1'b0;
    logic       bit_dout = 1'b0;
    logic       bit_al = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    i2c_byte_ctrl dut (
        .i_clk(clk), .i_rstn(rstn), .i_enable(enable), .i_ien(ien),
        .i_cmd_valid(cmd_valid), .i_cmd_start(cmd_start), .i_cmd_stop(cmd_stop),
        .i_cmd_read(cmd_read), .i_cmd_write(cmd_write), .i_cmd_ack(cmd_ack),
        .i_cmd_iack(cmd_iack), .i_tx_data(tx_data), .o_rx_data(rx_data),
        .o_tip(tip), .o_ip(ip), .o_al(al), .o_rxack(rxack), .o_irq(irq),
        .o_bit_cmd(bit_cmd), .o_bit_cmd_valid(bit_cmd_valid), .o_bit_din(bit_din),
        .i_bit_ack(bit_ack), .i_bit_dout(bit_dout), .i_bit_al(bit_al)
    );

    // One-cycle register write to i2c_command; flags = {start,stop,read,write,ack,iack}.
    task automatic issue_cmd(input logic [5:0] flags, input logic [7:0] data);
        {cmd_start, cmd_stop, cmd_read, cmd_write, cmd_ack, cmd_iack} = flags;
        tx_data   = data;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        {cmd_start, cmd_stop, cmd_read, cmd_write, cmd_ack, cmd_iack} = 6'b0;
    endtask

    // Bit-engine model: wait for a command, capture it, ack it 4 cycles later.
    task automatic serve_bit(input logic dout, output logic [2:0] cmd,
                             output logic din, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bit_cmd_valid) ok = 1'b1;
            else @(negedge clk);
        end
        cmd = bit_cmd;
        din = bit_din;
        if (ok) begin
            repeat (3) @(negedge clk);
            bit_ack  = 1'b1;
            bit_dout = dout;
            @(negedge clk);
            bit_ack  = 1'b0;
            bit_dout = 1'b0;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({rx_data, tip, ip, al, rxack, irq, bit_cmd, bit_cmd_valid, bit_din} !== 17'h0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got rx=%h tip=%b ip=%b al=%b rxack=%b irq=%b cmd=%0d v=%b din=%b, need all 0",
                     rx_data, tip, ip, al, rxack, irq, bit_cmd, bit_cmd_valid, bit_din);
        end
        rstn   = 1'b1;
        enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [2:0] cmd; logic din, ok;
        logic [7:0] tx = 8'hA5;
        ien = 1'b1;
        issue_cmd(6'b100100, tx);
        total++;
        if (tip !== 1'b1 || bit_cmd_valid !== 1'b1) begin
            bad++; $display("[TB] FAIL write_accept: tip=%b valid=%b, need 1 1", tip, bit_cmd_valid);
        end
        serve_bit(1'b0, cmd, din, ok);
        total++;
        if (!ok || cmd !== BIT_START) begin
            bad++; $display("[TB] FAIL write_start: cmd=%0d ok=%b, need %0d", cmd, ok, BIT_START);
        end
        for (int i = 7; i >= 0; i--) begin
            serve_bit(1'b0, cmd, din, ok);
            total++;
            if (!ok || cmd !== BIT_WRITE || din !== tx[i]) begin
                bad++; $display("[TB] FAIL write_bit%0d: cmd=%0d din=%b ok=%b, need cmd=%0d din=%b",
                                i, cmd, din, ok, BIT_WRITE, tx[i]);
            end
        end
        serve_bit(1'b0, cmd, din, ok);
        total++;
        if (!ok || cmd !== BIT_READ) begin
            bad++; $display("[TB] FAIL write_ackslot: cmd=%0d ok=%b, need %0d", cmd, ok, BIT_READ);
        end
        total++;
        if ({tip, ip, rxack, irq, bit_cmd_valid} !== 5'b01010) begin
            bad++; $display("[TB] FAIL write_done: tip/ip/rxack/irq/valid=%b, need 01010",
                            {tip, ip, rxack, irq, bit_cmd_valid});
        end
    endtask

    task automatic test_empty_cmd();
        int seen = 0;
        issue_cmd(6'b000000, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            if (bit_cmd_valid || tip) seen++;
            @(negedge clk);
        end
        total++;
        if (seen !== 0 || ip !== 1'b1) begin
            bad++; $display("[TB] FAIL empty_cmd: active cycles=%0d ip=%b, need 0 and ip=1", seen, ip);
        end
        issue_cmd(6'b000001, 8'h00);
        total++;
        if (ip !== 1'b0 || tip !== 1'b0) begin
            bad++; $display("[TB] FAIL iack_clear: ip=%b tip=%b, need 0 0", ip, tip);
        end
    endtask

    task automatic test_read();
        logic [2:0] cmd; logic din, ok;
        logic [7:0] bus = 8'h3C;
        ien = 1'b0;
        issue_cmd(6'b011010, 8'h00);
        for (int i = 7; i >= 0; i--) begin
            serve_bit(bus[i], cmd, din, ok);
            total++;
            if (!ok || cmd !== BIT_READ) begin
                bad++; $display("[TB] FAIL read_bit%0d: cmd=%0d ok=%b, need %0d", i, cmd, ok, BIT_READ);
            end
        end
        total++;
        if (rx_data !== 8'h3C) begin
            bad++; $display("[TB] FAIL read_rxdata: got %h, need 3c", rx_data);
        end
        serve_bit(1'b0, cmd, din, ok);
        total++;
        if (!ok || cmd !== BIT_WRITE || din !== 1'b1) begin
            bad++; $display("[TB] FAIL read_ackslot: cmd=%0d din=%b, need %0d din=1", cmd, din, BIT_WRITE);
        end
        serve_bit(1'b0, cmd, din, ok);
        total++;
        if (!ok || cmd !== BIT_STOP) begin
            bad++; $display("[TB] FAIL read_stop: cmd=%0d ok=%b, need %0d", cmd, ok, BIT_STOP);
        end
        total++;
        if ({tip, ip, irq, bit_cmd_valid} !== 4'b0100) begin
            bad++; $display("[TB] FAIL read_done: tip/ip/irq/valid=%b, need 0100", {tip, ip, irq, bit_cmd_valid});
        end
        issue_cmd(6'b000001, 8'h00);
    endtask

    task automatic test_al();
        logic [2:0] cmd; logic din, ok;
        int seen = 0;
        issue_cmd(6'b100100, 8'h5A);
        for (int i = 0; i < 4; i++) serve_bit(1'b0, cmd, din, ok);
        total++;
        if (bit_cmd_valid !== 1'b1 || bit_cmd !== BIT_WRITE || bit_din !== 1'b1) begin
            bad++; $display("[TB] FAIL al_fourth_bit: valid=%b cmd=%0d din=%b, need 1 %0d 1",
                            bit_cmd_valid, bit_cmd, bit_din, BIT_WRITE);
        end
        @(negedge clk);
        bit_al = 1'b1;
        @(negedge clk);
        bit_al = 1'b0;
        total++;
        if ({al, ip, tip, bit_cmd_valid} !== 4'b1100) begin
            bad++; $display("[TB] FAIL al_abort: al/ip/tip/valid=%b, need 1100", {al, ip, tip, bit_cmd_valid});
        end
        for (int i = 0; i < 10; i++) begin
            if (bit_cmd_valid) seen++;
            @(negedge clk);
        end
        total++;
        if (seen !== 0 || al !== 1'b1) begin
            bad++; $display("[TB] FAIL al_quiet: valid cycles=%0d al=%b, need 0 and al=1", seen, al);
        end
        issue_cmd(6'b000001, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic [2:0] cmd; logic din, ok;
        logic [7:0] tx = 8'h81;
        issue_cmd(6'b000100, tx);
        total++;
        if (al !== 1'b0 || ip !== 1'b0) begin
            bad++; $display("[TB] FAIL b2b_al_clear: al=%b ip=%b, need 0 0", al, ip);
        end
        for (int i = 7; i >= 0; i--) begin
            if (i == 5) issue_cmd(6'b101000, 8'hFF);
            serve_bit(1'b0, cmd, din, ok);
            total++;
            if (!ok || cmd !== BIT_WRITE || din !== tx[i]) begin
                bad++; $display("[TB] FAIL b2b_bit%0d: cmd=%0d din=%b ok=%b, need cmd=%0d din=%b",
                                i, cmd, din, ok, BIT_WRITE, tx[i]);
            end
        end
        total++;
        if (bit_cmd_valid !== 1'b1 || bit_cmd !== BIT_READ) begin
            bad++; $display("[TB] FAIL b2b_ackslot: valid=%b cmd=%0d, need 1 %0d", bit_cmd_valid, bit_cmd, BIT_READ);
        end
        repeat (3) @(negedge clk);
        bit_ack = 1'b1; bit_dout = 1'b1;
        cmd_valid = 1'b1; cmd_iack = 1'b1;
        @(negedge clk);
        bit_ack = 1'b0; bit_dout = 1'b0;
        cmd_valid = 1'b0; cmd_iack = 1'b0;
        total++;
        if ({tip, ip, rxack, bit_cmd_valid} !== 4'b0110) begin
            bad++; $display("[TB] FAIL b2b_iack_done: tip/ip/rxack/valid=%b, need 0110", {tip, ip, rxack, bit_cmd_valid});
        end
        repeat (3) @(negedge clk);
        total++;
        if (tip !== 1'b0 || bit_cmd_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL b2b_no_replay: tip=%b valid=%b, need 0 0", tip, bit_cmd_valid);
        end
    endtask

    task automatic test_disable();
        logic [2:0] cmd; logic din, ok;
        issue_cmd(6'b000001, 8'h00);
        issue_cmd(6'b101000, 8'h00);
        serve_bit(1'b0, cmd, din, ok);
        serve_bit(1'b1, cmd, din, ok);
        serve_bit(1'b0, cmd, din, ok);
        total++;
        if (bit_cmd_valid !== 1'b1 || bit_cmd !== BIT_READ) begin
            bad++; $display("[TB] FAIL dis_in_read: valid=%b cmd=%0d, need 1 %0d", bit_cmd_valid, bit_cmd, BIT_READ);
        end
        enable = 1'b0;
        @(negedge clk);
        total++;
        if ({tip, ip, bit_cmd_valid} !== 3'b000) begin
            bad++; $display("[TB] FAIL dis_abort: tip/ip/valid=%b, need 000", {tip, ip, bit_cmd_valid});
        end
        rstn = 1'b0;
        @(negedge clk);
        total++;
        if ({rx_data, tip, ip, al, rxack, irq, bit_cmd, bit_cmd_valid, bit_din} !== 17'h0) begin
            bad++; $display("[TB] FAIL dis_reset: got rx=%h tip=%b ip=%b al=%b rxack=%b irq=%b cmd=%0d v=%b din=%b, need all 0",
                            rx_data, tip, ip, al, rxack, irq, bit_cmd, bit_cmd_valid, bit_din);
        end
        rstn   = 1'b1;
        enable = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write();
        test_empty_cmd();
        test_read();
        test_al();
        test_back_to_back();
        test_disable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
